// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: MIPS exception codes,
// FSM state encoding and the exception check applied when an op is accepted.
package mem_access_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Overflow outranks alignment; a load+store op counts as a load.
    function automatic logic [4:0] accept_exc(
        input logic       ovf,
        input logic       is_mem,
        input logic       is_load,
        input logic [1:0] addr_lo
    );
        if (ovf) begin
            return EXC_OV;
        end
        if (is_mem && (addr_lo != 2'b00)) begin
            return is_load ? EXC_ADEL : EXC_ADES;
        end
        return EXC_NONE;
    endfunction

    function automatic logic rd_writable(input logic [4:0] rd);
        return rd != 5'd0;
    endfunction

endpackage

// File: rtl/mem_access_stage_timeout_ctr.sv
// Cycle counter for an outstanding data-memory request; flags the last
// cycle the stage is willing to wait for an acknowledge.
module mem_access_stage_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage between the ALU and the register-file write port:
// word load/store over a req/ack bus, writeback record and exception reporting.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_alu_result,
    input  logic              i_alu_ovf,
    input  logic [4:0]        i_rd,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [31:0]       i_store_data,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic              o_wb_we,
    output logic [4:0]        o_wb_rd,
    output logic [31:0]       o_wb_data,
    output logic              o_exc_valid,
    output logic [4:0]        o_exc_code
);

    state_t r_state;
    state_t w_state_next;

    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [31:0]       r_dmem_wdata;
    logic [31:0]       r_mem_alu;
    logic [4:0]        r_mem_rd;
    logic              r_mem_is_load;

    logic        r_wb_valid;
    logic        r_wb_we;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_exc_valid;
    logic [4:0]  r_exc_code;

    logic        w_wb_valid_next;
    logic        w_wb_we_next;
    logic [4:0]  w_wb_rd_next;
    logic [31:0] w_wb_data_next;
    logic        w_exc_valid_next;
    logic [4:0]  w_exc_code_next;

    logic        w_transfer;
    logic        w_is_mem;
    logic [4:0]  w_acc_exc;
    logic        w_start_mem;
    logic        w_in_wait;
    logic        w_expired;
    logic        w_mem_done;

    assign w_in_wait   = (r_state == ST_MEM_WAIT);
    assign o_in_ready  = (r_state == ST_IDLE) && (!r_wb_valid || i_wb_ready);
    assign w_transfer  = i_in_valid && o_in_ready;
    assign w_is_mem    = i_mem_read || i_mem_write;
    assign w_acc_exc   = accept_exc(i_alu_ovf, w_is_mem, i_mem_read, i_alu_result[1:0]);
    assign w_start_mem = w_transfer && w_is_mem && (w_acc_exc == EXC_NONE);
    // An acknowledge in the final allowed cycle completes the access normally.
    assign w_mem_done  = w_in_wait && (i_dmem_ack || w_expired);

    mem_access_stage_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (!w_in_wait || w_mem_done),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next     = r_state;
        w_wb_valid_next  = r_wb_valid && !i_wb_ready;
        w_wb_we_next     = r_wb_we;
        w_wb_rd_next     = r_wb_rd;
        w_wb_data_next   = r_wb_data;
        w_exc_valid_next = r_exc_valid;
        w_exc_code_next  = r_exc_code;

        if (r_wb_valid && i_wb_ready) begin
            w_wb_we_next     = 1'b0;
            w_exc_valid_next = 1'b0;
            w_exc_code_next  = EXC_NONE;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start_mem) begin
                    w_state_next = ST_MEM_WAIT;
                end else if (w_transfer) begin
                    w_wb_valid_next  = 1'b1;
                    w_wb_rd_next     = i_rd;
                    w_wb_data_next   = i_alu_result;
                    w_exc_valid_next = (w_acc_exc != EXC_NONE);
                    w_exc_code_next  = w_acc_exc;
                    w_wb_we_next     = (w_acc_exc == EXC_NONE) && i_reg_write
                                       && rd_writable(i_rd);
                end
            end
            ST_MEM_WAIT: begin
                if (i_dmem_ack) begin
                    w_state_next     = ST_IDLE;
                    w_wb_valid_next  = 1'b1;
                    w_wb_rd_next     = r_mem_rd;
                    w_wb_data_next   = r_mem_is_load ? i_dmem_rdata : r_mem_alu;
                    w_wb_we_next     = r_mem_is_load && rd_writable(r_mem_rd);
                    w_exc_valid_next = 1'b0;
                    w_exc_code_next  = EXC_NONE;
                end else if (w_expired) begin
                    w_state_next     = ST_IDLE;
                    w_wb_valid_next  = 1'b1;
                    w_wb_rd_next     = r_mem_rd;
                    w_wb_data_next   = r_mem_alu;
                    w_wb_we_next     = 1'b0;
                    w_exc_valid_next = 1'b1;
                    w_exc_code_next  = EXC_DBE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus request fields are captured once at accept and held until completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_dmem_addr   <= '0;
            r_dmem_wdata  <= '0;
            r_mem_alu     <= '0;
            r_mem_rd      <= '0;
            r_mem_is_load <= 1'b0;
        end else if (w_start_mem) begin
            r_dmem_req    <= 1'b1;
            r_dmem_we     <= i_mem_write && !i_mem_read;
            r_dmem_addr   <= i_alu_result[ADDR_W+1:2];
            r_dmem_wdata  <= i_store_data;
            r_mem_alu     <= i_alu_result;
            r_mem_rd      <= i_rd;
            r_mem_is_load <= i_mem_read;
        end else if (w_mem_done) begin
            r_dmem_req    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_exc_valid <= 1'b0;
            r_exc_code  <= EXC_NONE;
        end else begin
            r_wb_valid  <= w_wb_valid_next;
            r_wb_we     <= w_wb_we_next;
            r_wb_rd     <= w_wb_rd_next;
            r_wb_data   <= w_wb_data_next;
            r_exc_valid <= w_exc_valid_next;
            r_exc_code  <= w_exc_code_next;
        end
    end

    assign o_dmem_req   = r_dmem_req;
    assign o_dmem_we    = r_dmem_we;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_wdata = r_dmem_wdata;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_we      = r_wb_we;
    assign o_wb_rd      = r_wb_rd;
    assign o_wb_data    = r_wb_data;
    assign o_exc_valid  = r_exc_valid;
    assign o_exc_code   = r_exc_code;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a record-level reference model.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_alu_result;
    logic        i_alu_ovf;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [31:0] i_store_data;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [13:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic        o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_exc_valid;
    logic [4:0]  o_exc_code;

    mem_access_stage #(.ADDR_W(14), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_alu_result (i_alu_result),
        .i_alu_ovf    (i_alu_ovf),
        .i_rd         (i_rd),
        .i_reg_write  (i_reg_write),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_store_data (i_store_data),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_wb_valid   (o_wb_valid),
        .i_wb_ready   (i_wb_ready),
        .o_wb_we      (o_wb_we),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_exc_valid  (o_exc_valid),
        .o_exc_code   (o_exc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An op plus the memory's planned behaviour: ack on the lat-th request cycle.
    typedef struct {
        logic [31:0] alu;
        logic        ovf;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
        int          lat;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [4:0]  code;
    } rec_t;

    typedef struct {
        string       name;
        op_t         op;
        logic        e_we;
        logic [31:0] e_data;
        logic [4:0]  e_code;
        int          e_lat;
        int          e_req;
        logic [13:0] e_addr;
        logic        e_dwe;
    } vec_t;

    localparam int MAX_WAIT = 16;
    localparam int NEVER    = 99;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bounded wait expired or protocol broken", nm);
    endtask

    // Reference model: the record an op must produce, from the ISA-level rules.
    function automatic rec_t model(input op_t op);
        rec_t r;
        logic is_mem;
        is_mem  = op.mr || op.mw;
        r.rd    = op.rd;
        r.data  = op.alu;
        r.we    = 1'b0;
        r.exc   = 1'b1;
        if (op.ovf) begin
            r.code = 5'd12;
        end else if (is_mem && (op.alu % 4 != 0)) begin
            r.code = op.mr ? 5'd4 : 5'd5;
        end else if (is_mem && op.lat > MAX_WAIT) begin
            r.code = 5'd7;
        end else begin
            r.exc  = 1'b0;
            r.code = 5'd0;
            if (op.mr) begin
                r.data = op.rdata;
                r.we   = (op.rd != 0);
            end else if (!op.mw) begin
                r.we   = op.rw && (op.rd != 0);
            end
        end
        return r;
    endfunction

    function automatic op_t gen_op();
        op_t o;
        int  kind;
        int  r;
        kind    = $urandom_range(0, 9);
        o.mr    = (kind >= 4 && kind <= 6) || kind == 9;
        o.mw    = (kind >= 7);
        o.alu   = $urandom;
        if ((o.mr || o.mw) && $urandom_range(0, 5) != 0) o.alu[1:0] = 2'b00;
        o.ovf   = ($urandom_range(0, 9) == 0);
        o.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        o.rw    = 1'($urandom_range(0, 1));
        o.sd    = $urandom;
        o.rdata = $urandom;
        r       = $urandom_range(0, 19);
        o.lat   = (r < 16) ? 1 + (r % 8) : (r < 18) ? MAX_WAIT : NEVER;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        i_alu_result = o.alu;
        i_alu_ovf    = o.ovf;
        i_rd         = o.rd;
        i_reg_write  = o.rw;
        i_mem_read   = o.mr;
        i_mem_write  = o.mw;
        i_store_data = o.sd;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int seen;
        int n;
        @(negedge clk);
        i_wb_ready = 1'b1;
        i_dmem_ack = 1'b0;
        drive_op(v.op);
        i_in_valid = 1'b1;
        #1;
        n = 0;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 50) fail_now({v.name, "_accept"});
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        k = 0;
        seen = 0;
        for (int c = 1; c <= 40 && seen == 0; c++) begin
            @(negedge clk);
            i_dmem_ack = 1'b0;
            if (o_wb_valid) begin
                seen = c;
                chk({v.name, "_we"},   32'(o_wb_we),     32'(v.e_we));
                chk({v.name, "_rd"},   32'(o_wb_rd),     32'(v.op.rd));
                chk({v.name, "_data"}, o_wb_data,        v.e_data);
                chk({v.name, "_exc"},  32'(o_exc_valid), 32'(v.e_code != 5'd0));
                chk({v.name, "_code"}, 32'(o_exc_code),  32'(v.e_code));
            end else if (o_dmem_req) begin
                k++;
                if (k == v.op.lat) begin
                    i_dmem_ack   = 1'b1;
                    i_dmem_rdata = v.op.rdata;
                    chk({v.name, "_addr"}, 32'(o_dmem_addr), 32'(v.e_addr));
                    chk({v.name, "_dwe"},  32'(o_dmem_we),   32'(v.e_dwe));
                    if (v.e_dwe) chk({v.name, "_wdata"}, o_dmem_wdata, v.op.sd);
                end
            end
        end
        if (seen == 0) fail_now({v.name, "_wb_timeout"});
        chk({v.name, "_lat"},  32'(seen), 32'(v.e_lat));
        chk({v.name, "_reqc"}, 32'(k),    32'(v.e_req));
        $display("vec %-10s latency=%0d req_cycles=%0d data=0x%08h code=%0d",
                 v.name, seen, k, o_wb_data, o_exc_code);
    endtask

    vec_t vecs[12];
    op_t  plan_q[$];
    rec_t exp_q[$];

    initial begin
        op_t  cur;
        op_t  cur_plan;
        op_t  o;
        rec_t e;
        bit   have_op;
        int   ops_left;
        int   k_rand;
        int   cycles;

        rst_n = 1'b0;
        i_in_valid = 1'b0;
        i_alu_result = '0;
        i_alu_ovf = 1'b0;
        i_rd = '0;
        i_reg_write = 1'b0;
        i_mem_read = 1'b0;
        i_mem_write = 1'b0;
        i_store_data = '0;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = '0;
        i_wb_ready = 1'b1;

        //           name        alu           ovf   rd     rw    mr    mw    sd            lat    rdata
        vecs[0]  = '{"add5",    '{32'h5,        1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 32'h0,        1,     32'h0},
                     1'b1, 32'h5,        5'd0,  1,  0,  14'h0,   1'b0};
        vecs[1]  = '{"lw40",    '{32'h40,       1'b0, 5'd8,  1'b1, 1'b1, 1'b0, 32'h0,        3,     32'hDEADBEEF},
                     1'b1, 32'hDEADBEEF, 5'd0,  4,  3,  14'h10,  1'b0};
        vecs[2]  = '{"sw42",    '{32'h42,       1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 32'h1234,     1,     32'h0},
                     1'b0, 32'h42,       5'd5,  1,  0,  14'h0,   1'b0};
        vecs[3]  = '{"addovf",  '{32'h80000000, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 32'h0,        1,     32'h0},
                     1'b0, 32'h80000000, 5'd12, 1,  0,  14'h0,   1'b0};
        vecs[4]  = '{"lwtmo",   '{32'h100,      1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 32'h0,        NEVER, 32'h0},
                     1'b0, 32'h100,      5'd7,  17, 16, 14'h40,  1'b0};
        vecs[5]  = '{"lwack16", '{32'h104,      1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 32'h0,        16,    32'hCAFEF00D},
                     1'b1, 32'hCAFEF00D, 5'd0,  17, 16, 14'h41,  1'b0};
        vecs[6]  = '{"addr0",   '{32'h7,        1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0,        1,     32'h0},
                     1'b0, 32'h7,        5'd0,  1,  0,  14'h0,   1'b0};
        vecs[7]  = '{"lw41",    '{32'h41,       1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 32'h0,        1,     32'h0},
                     1'b0, 32'h41,       5'd4,  1,  0,  14'h0,   1'b0};
        vecs[8]  = '{"sw200",   '{32'h200,      1'b0, 5'd6,  1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1,     32'h0},
                     1'b0, 32'h200,      5'd0,  2,  1,  14'h80,  1'b1};
        vecs[9]  = '{"lwsw8",   '{32'h8,        1'b0, 5'd2,  1'b0, 1'b1, 1'b1, 32'h99,       2,     32'h77},
                     1'b1, 32'h77,       5'd0,  3,  2,  14'h2,   1'b0};
        vecs[10] = '{"lwrd0",   '{32'hC,        1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 32'h0,        1,     32'h55},
                     1'b0, 32'h55,       5'd0,  2,  1,  14'h3,   1'b0};
        vecs[11] = '{"lwovf",   '{32'h3,        1'b1, 5'd1,  1'b1, 1'b1, 1'b0, 32'h0,        1,     32'h0},
                     1'b0, 32'h3,        5'd12, 1,  0,  14'h0,   1'b0};

        // Reset state
        #12;
        chk("rst_req",   32'(o_dmem_req),  32'h0);
        chk("rst_wbv",   32'(o_wb_valid),  32'h0);
        chk("rst_exc",   32'(o_exc_valid), 32'h0);
        chk("rst_data",  o_wb_data,        32'h0);
        chk("rst_addr",  32'(o_dmem_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(o_in_ready),  32'h1);
        $display("reset released");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: consumer stalls with two adds queued
        @(negedge clk);
        i_wb_ready = 1'b0;
        i_dmem_ack = 1'b0;
        o = '{32'h11, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 1, 32'h0};
        drive_op(o);
        i_in_valid = 1'b1;
        @(posedge clk);
        #1;
        o.alu = 32'h22;
        o.rd  = 5'd2;
        drive_op(o);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("bp_ready", 32'(o_in_ready), 32'h0);
            chk("bp_valid", 32'(o_wb_valid), 32'h1);
            chk("bp_hold",  o_wb_data,       32'h11);
        end
        @(negedge clk);
        i_wb_ready = 1'b1;
        #1;
        chk("bp_release", 32'(o_in_ready), 32'h1);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_v", 32'(o_wb_valid), 32'h1);
        chk("bp_second_d", o_wb_data,       32'h22);
        chk("bp_second_r", 32'(o_wb_rd),    32'h2);
        @(negedge clk);
        chk("bp_drained",  32'(o_wb_valid), 32'h0);
        $display("seq backpressure second=0x%08h", 32'h22);

        // Asynchronous reset in the middle of a load
        @(negedge clk);
        o = '{32'h80, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'h0};
        drive_op(o);
        i_in_valid = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        @(negedge clk);
        chk("ar_req_up", 32'(o_dmem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req_drop", 32'(o_dmem_req), 32'h0);
        chk("ar_wbv_drop", 32'(o_wb_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ar_late_req", 32'(o_dmem_req), 32'h0);
            chk("ar_late_wbv", 32'(o_wb_valid), 32'h0);
        end
        i_dmem_ack = 1'b0;
        $display("seq async reset during wait");

        // Randomized traffic against the reference model
        have_op  = 1'b0;
        ops_left = 300;
        k_rand   = 0;
        cycles   = 0;
        cur      = gen_op();
        cur_plan = cur;
        while ((ops_left > 0 || have_op || exp_q.size() > 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            i_dmem_ack   = 1'b0;
            i_dmem_rdata = $urandom;
            if (o_dmem_req) begin
                if (k_rand == 0) begin
                    if (plan_q.size() == 0) fail_now("rnd_unexpected_req");
                    else cur_plan = plan_q.pop_front();
                end
                k_rand++;
                if (k_rand > MAX_WAIT) fail_now("rnd_req_too_long");
                if (k_rand == cur_plan.lat) begin
                    i_dmem_ack   = 1'b1;
                    i_dmem_rdata = cur_plan.rdata;
                    chk("rnd_addr", 32'(o_dmem_addr), 32'(cur_plan.alu[15:2]));
                    chk("rnd_dwe",  32'(o_dmem_we),   32'(cur_plan.mw && !cur_plan.mr));
                    if (cur_plan.mw && !cur_plan.mr) chk("rnd_wdata", o_dmem_wdata, cur_plan.sd);
                end
            end else begin
                k_rand     = 0;
                i_dmem_ack = ($urandom_range(0, 5) == 0);
            end

            i_wb_ready = ($urandom_range(0, 3) != 0);
            if (!have_op && ops_left > 0 && $urandom_range(0, 4) != 0) begin
                cur      = gen_op();
                have_op  = 1'b1;
                ops_left--;
            end
            i_in_valid = have_op;
            if (have_op) drive_op(cur);
            else drive_op(gen_op());
            #1;

            if (o_wb_valid && i_wb_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("rnd_extra_record");
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_we",   32'(o_wb_we),     32'(e.we));
                    chk("rnd_rd",   32'(o_wb_rd),     32'(e.rd));
                    chk("rnd_data", o_wb_data,        e.data);
                    chk("rnd_exc",  32'(o_exc_valid), 32'(e.exc));
                    chk("rnd_code", 32'(o_exc_code),  32'(e.code));
                    $display("rnd rec rd=%0d we=%0b data=0x%08h exc=%0b code=%0d",
                             o_wb_rd, o_wb_we, o_wb_data, o_exc_valid, o_exc_code);
                end
            end
            if (i_in_valid && o_in_ready) begin
                exp_q.push_back(model(cur));
                if ((cur.mr || cur.mw) && !cur.ovf && cur.alu[1:0] == 2'b00)
                    plan_q.push_back(cur);
                have_op = 1'b0;
            end
        end
        if (exp_q.size() != 0 || have_op || ops_left != 0) fail_now("rnd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
